// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo motion sequencer.
// Commands are {target, step} magnitudes in PWM-block units.
package servo_pkg;
  localparam int MAG_W         = 17;
  localparam int CMD_W         = 2 * MAG_W;
  localparam int MAG_MIN_DEF   = 1600;
  localparam int MAG_MAX_DEF   = 9600;
  localparam int MAG_RESET_DEF = 5600;

  typedef enum logic [1:0] {IDLE, LOAD, SLEW, SETTLE} motion_state_t;

  typedef struct packed {
    logic [MAG_W-1:0] target;
    logic [MAG_W-1:0] step;
  } servo_cmd_t;

  function automatic logic [MAG_W-1:0] clamp_mag(input logic [MAG_W-1:0] v,
                                                 input logic [MAG_W-1:0] lo,
                                                 input logic [MAG_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for queued motion commands; reset empties it.
// A push is refused while full, even when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/servo_motion_ctrl.sv
// Slews a servo PWM magnitude toward queued targets once per frame,
// then holds each target for a settle interval before the next command.
module servo_motion_ctrl
  import servo_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int FRAME_HZ      = 50,
  parameter int MAG_MIN       = MAG_MIN_DEF,
  parameter int MAG_MAX       = MAG_MAX_DEF,
  parameter int MAG_RESET     = MAG_RESET_DEF,
  parameter int SETTLE_FRAMES = 5,
  parameter int DEPTH         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [MAG_W-1:0] cmd_target,
  input  logic [MAG_W-1:0] cmd_step,
  input  logic             hold,
  output logic [MAG_W-1:0] magnitude,
  output logic             busy,
  output logic             done,
  output logic             frame_tick,
  output motion_state_t    dbg_state
);
  localparam int FRAME_CYCLES = CLK_HZ / FRAME_HZ;
  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int SW = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [CW-1:0]    FRAME_LAST  = CW'(FRAME_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_FRAMES - 1);
  localparam logic [MAG_W-1:0] MIN_C = MAG_W'(MAG_MIN);
  localparam logic [MAG_W-1:0] MAX_C = MAG_W'(MAG_MAX);
  localparam logic [MAG_W-1:0] RST_C = MAG_W'(MAG_RESET);

  logic [CW-1:0]           frame_cnt_q;
  motion_state_t           state_q, state_d;
  logic [MAG_W-1:0]        mag_q, mag_d, tgt_q, tgt_d, step_q, step_d, slew_mag;
  servo_cmd_t              cmd_q, cmd_d, head_cmd;
  logic [SW-1:0]           settle_q, settle_d;
  logic [CMD_W-1:0]        fifo_rdata;
  logic                    fifo_full, fifo_empty, pop, advance;
  logic signed [MAG_W:0]   diff;
  logic [MAG_W:0]          abs_diff;

  // Free-running frame timebase, independent of hold and the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else if (frame_cnt_q == FRAME_LAST) frame_cnt_q <= '0;
    else frame_cnt_q <= frame_cnt_q + CW'(1);
  end

  assign frame_tick = (frame_cnt_q == FRAME_LAST);
  assign advance    = frame_tick & ~hold;

  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_cmd_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (cmd_valid),
    .pop_i   (pop),
    .wdata_i ({cmd_target, cmd_step}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_cmd  = fifo_rdata;
  assign cmd_ready = ~fifo_full;
  assign magnitude = mag_q;
  assign busy      = (state_q != IDLE) | ~fifo_empty;
  assign dbg_state = state_q;

  // 18-bit difference: both operands lie in [MAG_MIN, MAG_MAX], so no wrap.
  always_comb begin
    diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, mag_q});
    abs_diff = diff[MAG_W] ? $unsigned(-diff) : $unsigned(diff);
    if (step_q == '0 || abs_diff <= {1'b0, step_q}) slew_mag = tgt_q;
    else if (diff[MAG_W])                           slew_mag = mag_q - step_q;
    else                                            slew_mag = mag_q + step_q;
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    cmd_d    = cmd_q;
    settle_d = settle_q;
    pop      = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = head_cmd;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tgt_d   = clamp_mag(cmd_q.target, MIN_C, MAX_C);
        step_d  = cmd_q.step;
        state_d = SLEW;
      end
      SLEW: begin
        if (mag_q == tgt_q) begin
          settle_d = '0;
          state_d  = SETTLE;
        end else if (advance) begin
          mag_d = slew_mag;
        end
      end
      SETTLE: begin
        if (advance) begin
          if (settle_q == SETTLE_LAST) begin
            done = 1'b1;
            if (!fifo_empty) begin
              pop     = 1'b1;
              cmd_d   = head_cmd;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mag_q    <= RST_C;
      tgt_q    <= RST_C;
      step_q   <= '0;
      cmd_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      cmd_q    <= cmd_d;
      settle_q <= settle_d;
    end
  end
endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Bench for servo_motion_ctrl with 10-cycle frames and a 2-frame settle.
// A command-level model predicts every magnitude change and done target.
module tb_servo_motion_ctrl;
  import servo_pkg::*;

  logic          clk = 1'b0;
  logic          reset, cmd_valid, hold;
  logic [16:0]   cmd_target, cmd_step;
  logic          cmd_ready, busy, done, frame_tick;
  logic [16:0]   magnitude;
  motion_state_t dbg_state;

  always #5 clk = ~clk;

  servo_motion_ctrl #(
    .CLK_HZ(1000), .FRAME_HZ(100), .SETTLE_FRAMES(2), .DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .hold(hold),
    .magnitude(magnitude), .busy(busy), .done(done), .frame_tick(frame_tick),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] done_exp_q[$];
  int model_mag = 5600;
  int change_cnt = 0;
  int done_cnt = 0;
  logic [16:0] prev_mag = 17'd5600;
  logic tick_prev = 1'b0;
  logic rand_done = 1'b0;

  typedef struct {
    logic [16:0] target;
    logic [16:0] step;
    logic [16:0] exp_mag;
    int          exp_changes;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model: clamp, then list every intermediate magnitude.
  task automatic model_accept(input int t, input int s);
    int tc, d, ad;
    tc = (t < 1600) ? 1600 : ((t > 9600) ? 9600 : t);
    while (model_mag != tc) begin
      d  = tc - model_mag;
      ad = (d < 0) ? -d : d;
      if (s == 0 || ad <= s) model_mag = tc;
      else if (d > 0)        model_mag = model_mag + s;
      else                   model_mag = model_mag - s;
      exp_q.push_back(17'(model_mag));
    end
    done_exp_q.push_back(17'(tc));
  endtask

  task automatic push_cmd(input logic [16:0] t, input logic [16:0] s, output int stalls);
    logic accepted;
    accepted = 1'b0;
    stalls = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_target = t; cmd_step = s;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin accepted = 1'b1; break; end
      stalls++;
    end
    if (!accepted) begin
      check("push_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      model_accept(int'(t), int'(s));
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check(name, 0, 1);
  endtask

  task automatic wait_tick(input int max_cycles, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (frame_tick) begin ok = 1'b1; break; end
    end
    if (!ok) check(name, 0, 1);
  endtask

  // Scoreboard monitor: every magnitude change and every done pulse.
  always @(negedge clk) begin
    if (reset) begin
      prev_mag  = magnitude;
      tick_prev = 1'b0;
    end else begin
      if (magnitude != prev_mag) begin
        change_cnt++;
        check("mag_after_tick", int'(tick_prev), 1);
        if (exp_q.size() > 0) check("mag_seq", int'(magnitude), int'(exp_q.pop_front()));
        else                  check("mag_spurious", int'(magnitude), int'(prev_mag));
        prev_mag = magnitude;
      end
      if (done) begin
        done_cnt++;
        if (done_exp_q.size() > 0) check("done_target", int'(magnitude), int'(done_exp_q.pop_front()));
        else                       check("done_spurious", 1, 0);
      end
      tick_prev = frame_tick;
    end
  end

  initial begin
    int stalls, ticks, n, c0, d0, rec;
    logic found;
    logic [16:0] rt, rs;

    vecs[0] = '{17'd20000, 17'd0,    17'd9600, 1};
    vecs[1] = '{17'd100,   17'd0,    17'd1600, 1};
    vecs[2] = '{17'd1600,  17'd500,  17'd1600, 0};
    vecs[3] = '{17'd2000,  17'd3000, 17'd2000, 1};
    vecs[4] = '{17'd1000,  17'd150,  17'd1600, 3};
    vecs[5] = '{17'd9600,  17'd4000, 17'd9600, 2};
    vecs[6] = '{17'd9599,  17'd1,    17'd9599, 1};
    vecs[7] = '{17'd6000,  17'd1200, 17'd6000, 3};

    reset = 1'b1; cmd_valid = 1'b0; hold = 1'b0; cmd_target = '0; cmd_step = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mag", int'(magnitude), 5600);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // Frame tick period.
    wait_tick(20, "tick_first_timeout");
    for (int k = 0; k < 2; k++) begin
      for (n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (frame_tick) break;
      end
      check("tick_period", n, 10);
    end

    // 5600 -> 8000 step 1000 with pop/load latency and settle timing.
    push_cmd(17'd8000, 17'd1000, stalls);
    @(negedge clk); check("lat_pop_idle", int'(dbg_state), int'(IDLE));
    @(negedge clk); check("lat_load", int'(dbg_state), int'(LOAD));
    @(negedge clk); check("lat_slew", int'(dbg_state), int'(SLEW));
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (magnitude == 17'd8000) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("reach_8000", int'(found), 1);
    ticks = 0; found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_tick) ticks++;
      if (done) begin found = 1'b1; break; end
    end
    check("settle_done_seen", int'(found), 1);
    check("settle_ticks", ticks, 2);
    check("done_on_tick", int'(frame_tick), 1);
    check("busy_at_done", int'(busy), 1);
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);

    // Table of single commands applied from a known start (8000).
    for (int v = 0; v < 8; v++) begin
      c0 = change_cnt; d0 = done_cnt;
      push_cmd(vecs[v].target, vecs[v].step, stalls);
      wait_idle(300, "vec_idle_timeout");
      @(negedge clk);
      check("vec_final_mag", int'(magnitude), int'(vecs[v].exp_mag));
      check("vec_changes", change_cnt - c0, vecs[v].exp_changes);
      check("vec_done", done_cnt - d0, 1);
    end

    // Back-to-back: one slow active command plus five queued.
    d0 = done_cnt;
    push_cmd(17'd9600, 17'd100, stalls);
    repeat (3) @(negedge clk);
    push_cmd(17'd2000, 17'd0, stalls);
    push_cmd(17'd9000, 17'd0, stalls);
    push_cmd(17'd3000, 17'd1000, stalls);
    push_cmd(17'd5000, 17'd0, stalls);
    @(negedge clk);
    check("fifo_full_ready", int'(cmd_ready), 0);
    push_cmd(17'd7000, 17'd2500, stalls);
    check("refused_stalled", int'(stalls > 0), 1);
    wait_idle(3000, "b2b_idle_timeout");
    check("b2b_done_count", done_cnt - d0, 6);
    check("b2b_mag", int'(magnitude), 7000);

    // Hold during slew, then hold during settle.
    c0 = change_cnt;
    push_cmd(17'd9600, 17'd100, stalls);
    for (int i = 0; i < 100 && change_cnt == c0; i++) @(negedge clk);
    wait_tick(20, "hold_tick_timeout");
    @(posedge clk); #1;
    hold = 1'b1;
    rec = int'(magnitude);
    ticks = 0;
    for (int i = 0; i < 60 && ticks < 3; i++) begin
      @(negedge clk);
      if (frame_tick) ticks++;
    end
    @(posedge clk); #1;
    hold = 1'b0;
    check("hold_slew_frozen", int'(magnitude), rec);
    wait_tick(20, "resume_tick_timeout");
    @(posedge clk); #1;
    check("hold_slew_resume", int'(magnitude), rec + 100);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dbg_state == SETTLE) begin found = 1'b1; break; end
    end
    check("settle_entry", int'(found), 1);
    hold = 1'b1; #1;
    ticks = 0; found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clk);
      if (frame_tick) ticks++;
      if (done) begin found = 1'b1; break; end
      if (ticks == 3 && hold) begin @(posedge clk); #1; hold = 1'b0; end
    end
    hold = 1'b0;
    check("hold_settle_done", int'(found), 1);
    check("hold_settle_ticks", ticks, 5);
    wait_idle(100, "hold_idle_timeout");

    // Randomised commands with random hold, checked by the model.
    d0 = done_cnt;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          rt = 17'($urandom_range(0, 12000));
          if ($urandom_range(0, 4) == 0) rt = 17'(model_mag);
          rs = ($urandom_range(0, 3) == 0) ? 17'd0 : 17'($urandom_range(200, 3000));
          push_cmd(rt, rs, stalls);
          repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        wait_idle(20000, "rand_idle_timeout");
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          hold = ($urandom_range(0, 3) == 0);
        end
        hold = 1'b0;
      end
    join
    @(negedge clk);
    check("rand_done_count", done_cnt - d0, 12);
    check("rand_exp_drained", exp_q.size(), 0);
    check("rand_done_drained", done_exp_q.size(), 0);
    check("rand_final_mag", int'(magnitude), model_mag);

    // Reset mid-slew with two commands queued.
    c0 = change_cnt;
    push_cmd((model_mag > 5600) ? 17'd1600 : 17'd9600, 17'd50, stalls);
    push_cmd(17'd1000, 17'd0, stalls);
    push_cmd(17'd9000, 17'd0, stalls);
    for (int i = 0; i < 500 && change_cnt < c0 + 2; i++) @(negedge clk);
    check("pre_reset_slew", int'(dbg_state), int'(SLEW));
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete(); done_exp_q.delete(); model_mag = 5600;
    #1;
    check("async_rst_mag", int'(magnitude), 5600);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(cmd_ready), 1);
    d0 = done_cnt;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("post_rst_no_done", done_cnt - d0, 0);
    check("post_rst_mag", int'(magnitude), 5600);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_state", int'(dbg_state), int'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/servo_motion_ctrl.md
# servo_motion_ctrl

Sequences position commands for one servo PWM channel. It accepts target commands through a valid/ready handshake into a small FIFO. It slews the servo `magnitude` toward each target at a per-command rate, updating once per 50 Hz servo frame. After arrival it holds each target for a settle interval before taking the next command. It sits between the control logic (host/joystick decoding) and the servo PWM block, driving that block's 17-bit `magnitude` input.

## Interface

Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency.
- `FRAME_HZ`, 50, update rate; `FRAME_CYCLES = CLK_HZ/FRAME_HZ`.
- `MAG_MIN`, 1600, lowest legal magnitude (1.0 ms pulse).
- `MAG_MAX`, 9600, highest legal magnitude (2.0 ms pulse, per the PWM block's clamp).
- `MAG_RESET`, 5600, magnitude after reset (centre).
- `SETTLE_FRAMES`, 5, frames held at target before the next command.
- `DEPTH`, 4, command FIFO depth (power of 2).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: **one clock; reset is asynchronous and active-high.**
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: FIFO not full.
- `cmd_target` input 17: target magnitude.
- `cmd_step` input 17: maximum change per frame. A value of 0 means jump.
- `hold` input 1: freezes motion and settle counting.
- `magnitude` output 17: to the PWM block.
- `busy` output 1: a command is active or the FIFO is non-empty.
- `done` output 1: one-cycle pulse when a command completes its settle interval.
- `frame_tick` output 1: one-cycle pulse each frame.

## Operation

- Frame counter: free-running from 0 to FRAME_CYCLES-1, then wraps. `frame_tick`=1 when the count equals FRAME_CYCLES-1. The counter is unaffected by `hold` and by the FSM state.
- FIFO push occurs when `cmd_valid & cmd_ready`.
  - `cmd_ready = !full`. When full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle are both performed when not full.
- FSM states: IDLE, LOAD, SLEW, SETTLE.
- IDLE: when the FIFO is non-empty, pop and go to LOAD.
- LOAD (1 cycle):
  - Latch `tgt = clamp(cmd_target, MAG_MIN, MAG_MAX)` and `step`, then go to SLEW.
- SLEW: on each `frame_tick` with `hold`=0:
  - If `step`=0 or `|tgt-magnitude| <= step`, set `magnitude <= tgt`.
  - Otherwise, `magnitude` moves by `step` toward `tgt`.
  - When `magnitude == tgt` (including at entry), go to SETTLE with the settle count = 0.
- SETTLE: each `frame_tick` with `hold`=0 increments the count.
  - On reaching SETTLE_FRAMES, pulse `done`.
  - Then go to LOAD if the FIFO is non-empty, else IDLE.
- Arithmetic: compute the difference at 18 bits. `magnitude` never leaves [MAG_MIN, MAG_MAX], and no wrap is possible.
- `busy = (state != IDLE) | !empty`.

## Timing

- Reset values:
  - `magnitude`=MAG_RESET, `cmd_ready`=1, `busy`=0, `done`=0, `frame_tick`=0.
  - FIFO empty, state IDLE, frame count 0.
- Reset asserted mid-operation: the FIFO is flushed, the active command is discarded, and `magnitude` returns to MAG_RESET immediately (asynchronously).
- Latency from push into an empty FIFO while in IDLE:
  - Pop on the cycle after the push.
  - LOAD one cycle later.
  - First magnitude change at the next `frame_tick` after entering SLEW.
- `magnitude` changes only on a `frame_tick` cycle (registered; visible the following cycle).
- `done` is asserted for exactly one cycle, coincident with the SETTLE exit transition.
- `hold` sampled high on a tick: that tick is ignored for both slew and settle. Releasing `hold` resumes on the next tick.
- A target equal to the current magnitude skips to SETTLE one cycle after LOAD.

## Structure

- Package `servo_pkg` contains:
  - `MAG_W=17`.
  - Defaults for MAG_MIN, MAG_MAX and MAG_RESET.
  - `typedef enum logic [1:0] {IDLE, LOAD, SLEW, SETTLE} motion_state_t`.
  - The command struct `{target, step}`.
- Sub-module `cmd_fifo` (parameterised DEPTH and width 34; push/pop/full/empty; reset flushes).
- The frame counter, clamp and FSM live in the top level.

## Test plan

Bench settings: CLK_HZ=1000, FRAME_HZ=100 (10-cycle frames), SETTLE_FRAMES=2.

- Reset → `magnitude`=5600 and `cmd_ready`=1. `frame_tick` pulses every 10 cycles.
- Push target 8000, step 1000 → `magnitude` goes 6600, 7600, 8000 on successive ticks. `done` pulses 2 ticks after reaching 8000; `busy` falls the following cycle.
- Push target 20000, step 0, then target 100, step 0 → the first jumps to 9600 and the second to 1600, with one `done` each, in order.
- Push 5 commands back-to-back while the first is active → `cmd_ready` drops after the FIFO fills. All accepted commands execute in FIFO order, and the refused one is not lost from the driver's perspective (its valid is held).
- Assert `hold` for 3 ticks during SLEW → `magnitude` is unchanged for those ticks and resumes stepping afterwards. `hold` during SETTLE delays `done` by 3 frames.
- Assert `reset` mid-SLEW with 2 commands queued → `magnitude`=5600 immediately, `busy`=0, and no `done` pulses afterwards.
